// File: rtl/mtm_alu_serializer.sv
// mtm_alu_serializer: output stage of the MTM ALU. Frames the 32-bit result C and the
// status byte CTL_out into 11-bit packets (start 0, type, 8 payload bits MSB first,
// stop 1) on a single idle-high serial line. A normal frame is four data packets
// (C[31:24] first) followed by one CMD packet; an error frame (CTL_out[7]=1) is the
// CMD packet alone.
// Optional feature: define MTM_ALU_SER_CRC_EN to have the serializer compute the CRC-3
// for normal frames itself; undefined, CTL_out is sent verbatim.
// Ports:
//   clk     - clock, all state changes on posedge
//   rst     - asynchronous active-low reset
//   C       - ALU result, latched on an accepted load
//   CTL_out - status byte, latched on an accepted load
//   load    - one-cycle transmit request, accepted only in IDLE
//   sout    - registered serial output, 1 when idle
//   busy    - registered, high while a frame's bits are on sout
module mtm_alu_serializer (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] C,
    input  logic [7:0]  CTL_out,
    input  logic        load,
    output logic        sout,
    output logic        busy
);

    localparam int unsigned DATA_PKTS = 4;
    localparam int unsigned PKT_W     = 3;
    localparam int unsigned BIT_W     = 3;

    typedef enum logic [2:0] {
        IDLE,
        START,
        TYPE,
        PAYLOAD,
        STOP
    } state_t;

    state_t             state;
    logic [PKT_W-1:0]   pkt;
    logic [BIT_W-1:0]   bit_cnt;
    logic [31:0]        c_q;
    logic [7:0]         ctl_q;
    logic [7:0]         cur_byte_c;
    logic [7:0]         ctl_tx_c;
    logic               cmd_pkt_c;

`ifdef MTM_ALU_SER_CRC_EN
    // Serial CRC-3, polynomial x^3+x+1, init 000, message MSB first.
    function automatic logic [2:0] crc3(input logic [36:0] msg);
        logic [2:0] r;
        logic       fb;
        r = 3'b000;
        for (int i = 36; i >= 0; i--) begin
            fb = msg[i] ^ r[2];
            r  = {r[1], r[0] ^ fb, fb};
        end
        return r;
    endfunction
`endif

    // CMD byte as it will be transmitted; error bytes always pass through untouched.
    always_comb begin
        ctl_tx_c = CTL_out;
`ifdef MTM_ALU_SER_CRC_EN
        if (!CTL_out[7]) begin
            ctl_tx_c = {CTL_out[7:3], crc3({C, 1'b0, CTL_out[6:3]})};
        end
`endif
    end

    assign cmd_pkt_c = (pkt == PKT_W'(DATA_PKTS));

    // Payload byte of the packet in flight.
    always_comb begin
        cur_byte_c = ctl_q;
        case (pkt)
            3'd0:    cur_byte_c = c_q[31:24];
            3'd1:    cur_byte_c = c_q[23:16];
            3'd2:    cur_byte_c = c_q[15:8];
            3'd3:    cur_byte_c = c_q[7:0];
            default: cur_byte_c = ctl_q;
        endcase
    end

    // Frame FSM; sout shows the bit belonging to the state just left.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            pkt     <= '0;
            bit_cnt <= '0;
            c_q     <= '0;
            ctl_q   <= '0;
            sout    <= 1'b1;
            busy    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    sout <= 1'b1;
                    busy <= 1'b0;
                    if (load) begin
                        c_q   <= C;
                        ctl_q <= ctl_tx_c;
                        pkt   <= CTL_out[7] ? PKT_W'(DATA_PKTS) : '0;
                        state <= START;
                    end
                end
                START: begin
                    sout    <= 1'b0;
                    busy    <= 1'b1;
                    bit_cnt <= BIT_W'(7);
                    state   <= TYPE;
                end
                TYPE: begin
                    sout  <= cmd_pkt_c;
                    state <= PAYLOAD;
                end
                PAYLOAD: begin
                    sout <= cur_byte_c[bit_cnt];
                    if (bit_cnt == '0) begin
                        state <= STOP;
                    end else begin
                        bit_cnt <= bit_cnt - BIT_W'(1);
                    end
                end
                STOP: begin
                    sout <= 1'b1;
                    if (cmd_pkt_c) begin
                        state <= IDLE;
                    end else begin
                        pkt   <= pkt + PKT_W'(1);
                        state <= START;
                    end
                end
                default: begin
                    sout  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
